ndp8_4_merge: RTL and testbench
===============================

NDP8_4_MERGE -- requirements
Module: ndp8_4_merge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 480, payload width per lane.
REQ-002 SHALL have parameter CTRL_WIDTH, default 32, control word width per lane.
REQ-003 SHALL have parameter FIFO_DEPTH_BITS, default 2, log2 of per-input queue depth (4 entries).
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_wrN, input, 1, write strobe for input lane N (N=0..7).
REQ-007 SHALL have ports in_ctlN, input, CTRL_WIDTH, control word for lane N; bits [1:0] select destination output 0..3.
REQ-008 SHALL have ports in_dataN, input, DATA_WIDTH, payload for lane N.
REQ-009 SHALL have port nearly_full, output, 8, bit N high when lane-N queue holds >= depth-1 entries.
REQ-010 SHALL have ports out_wrM, output, 1, registered write strobe for output M (M=0..3).
REQ-011 SHALL have ports out_ctlM, output, CTRL_WIDTH, registered control word for output M.
REQ-012 SHALL have ports out_dataM, output, DATA_WIDTH, registered payload for output M.
REQ-013 SHALL have port drop_cnt, output, 16, count of words discarded at full input queues.

Function
REQ-014 SHALL buffer each input lane in its own FIFO of 2^FIFO_DEPTH_BITS words of {ctl,data}, written when in_wrN=1 and queue not full.
REQ-015 SHALL discard a word whose in_wrN=1 arrives while its queue is full, and increment drop_cnt by 1, saturating at 16'hFFFF.
REQ-016 SHALL accept a write to a full queue that is popped in the same cycle (no drop).
REQ-017 SHALL, each cycle, for each output M, select at most one non-empty lane whose head ctl[1:0]==M, and pop that lane the same cycle.
REQ-018 SHALL pop at most one word per lane per cycle; lanes heading to distinct outputs SHALL be served in parallel (up to 4 grants/cycle).
REQ-019 SHALL register the granted head into out_ctlM/out_dataM with out_wrM=1 on the clock edge ending the grant cycle.
REQ-020 SHALL drive out_wrM=0 in cycles with no grant for M, holding out_ctlM/out_dataM at their last values.
REQ-021 SHALL have latency: word written at edge t is eligible for grant in cycle t..t+1 and appears on outputs at edge t+1 at minimum (2 clocks input-strobe to out_wr).
REQ-022 SHALL preserve per-lane order; words from one lane never reorder.
REQ-023 SHALL keep one 3-bit last-grant pointer per output, updated only on a grant to that output.
REQ-024 SHALL ignore ctl bits above [1:0] for routing and pass them through unchanged.

Reset
REQ-025 SHALL, while rst=0, clear all queues (empty), all out_wrM/out_ctlM/out_dataM to 0, drop_cnt to 0, all last-grant pointers to 7.
REQ-026 SHALL discard queued words when reset asserts mid-operation; no output strobe SHALL occur in the first edge after deassertion.

Configuration
REQ-027 SHALL support macro NDP84_ROUND_ROBIN_EN.
REQ-028 SHALL, with NDP84_ROUND_ROBIN_EN defined, arbitrate per output round-robin: search lanes starting at last-grant+1 modulo 8.
REQ-029 SHALL, without NDP84_ROUND_ROBIN_EN, arbitrate fixed priority, lane 0 highest, lane 7 lowest; pointers unused.

Verification
REQ-030 SHALL verify single word: in_wr3=1, ctl=32'h2, data=A at edge 0 -> out_wr2=1, out_data2=A at edge 2; other out_wr stay 0.
REQ-031 SHALL verify parallel: lanes 0..3 each write one word to outputs 3,2,1,0 same cycle -> all four out_wrM=1 in the same cycle, correct mapping.
REQ-032 SHALL verify contention with RR: lanes 0,1,2 each hold 2 words to output 1 -> out1 sequence lane 0,1,2,0,1,2; with macro off -> 0,0,1,1,2,2.
REQ-033 SHALL verify overflow: 6 back-to-back writes on lane 5 to output 0 while lane 0 floods output 0 (fixed priority) -> lane 5 queue fills, nearly_full[5]=1 at 3 entries, drop_cnt=2.
REQ-034 SHALL verify reset mid-traffic: assert rst with 3 words queued -> outputs 0 immediately, drop_cnt=0, no stale words emitted after release.
REQ-035 SHALL verify drop_cnt saturation: force 65540 drops -> drop_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/ndp8_4_merge.sv
// ndp8_4_merge: eight input lanes, each with its own small FIFO, merged onto
// four registered outputs selected by ctl[1:0] of each lane's head word.
// Build option: define NDP84_ROUND_ROBIN_EN for per-output round-robin
// arbitration; otherwise fixed priority (lane 0 highest, lane 7 lowest).
module ndp8_4_merge #(
  parameter int DATA_WIDTH      = 480,
  parameter int CTRL_WIDTH      = 32,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_wr0,
  input  logic [CTRL_WIDTH-1:0] in_ctl0,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic                  in_wr1,
  input  logic [CTRL_WIDTH-1:0] in_ctl1,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic                  in_wr2,
  input  logic [CTRL_WIDTH-1:0] in_ctl2,
  input  logic [DATA_WIDTH-1:0] in_data2,
  input  logic                  in_wr3,
  input  logic [CTRL_WIDTH-1:0] in_ctl3,
  input  logic [DATA_WIDTH-1:0] in_data3,
  input  logic                  in_wr4,
  input  logic [CTRL_WIDTH-1:0] in_ctl4,
  input  logic [DATA_WIDTH-1:0] in_data4,
  input  logic                  in_wr5,
  input  logic [CTRL_WIDTH-1:0] in_ctl5,
  input  logic [DATA_WIDTH-1:0] in_data5,
  input  logic                  in_wr6,
  input  logic [CTRL_WIDTH-1:0] in_ctl6,
  input  logic [DATA_WIDTH-1:0] in_data6,
  input  logic                  in_wr7,
  input  logic [CTRL_WIDTH-1:0] in_ctl7,
  input  logic [DATA_WIDTH-1:0] in_data7,
  output logic [7:0]            nearly_full,
  output logic                  out_wr0,
  output logic [CTRL_WIDTH-1:0] out_ctl0,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic                  out_wr1,
  output logic [CTRL_WIDTH-1:0] out_ctl1,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic                  out_wr2,
  output logic [CTRL_WIDTH-1:0] out_ctl2,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic                  out_wr3,
  output logic [CTRL_WIDTH-1:0] out_ctl3,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic [15:0]           drop_cnt
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int CNTW  = FIFO_DEPTH_BITS + 1;

  typedef logic [WW-1:0]              word_t;
  typedef logic [FIFO_DEPTH_BITS-1:0] ptr_t;
  typedef logic [CNTW-1:0]            cnt_t;

  logic [7:0] wr;
  word_t      wword [8];

  assign wr       = {in_wr7, in_wr6, in_wr5, in_wr4, in_wr3, in_wr2, in_wr1, in_wr0};
  assign wword[0] = {in_ctl0, in_data0};
  assign wword[1] = {in_ctl1, in_data1};
  assign wword[2] = {in_ctl2, in_data2};
  assign wword[3] = {in_ctl3, in_data3};
  assign wword[4] = {in_ctl4, in_data4};
  assign wword[5] = {in_ctl5, in_data5};
  assign wword[6] = {in_ctl6, in_data6};
  assign wword[7] = {in_ctl7, in_data7};

  word_t      mem_q  [8][DEPTH];
  ptr_t       wptr_q [8];
  ptr_t       rptr_q [8];
  cnt_t       cnt_q  [8];
  cnt_t       cnt_d  [8];
  word_t      head   [8];
  logic [7:0] nonempty, full, nf, push, pop, drop;

  logic [7:0] req      [4];
  logic [3:0] gnt_vld;
  logic [2:0] gnt_lane [4];
  logic [2:0] idx;

  logic [3:0] out_wr_q;
  word_t      out_word_q [4];

  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [3:0]  ndrop;
  logic [16:0] drop_sum;

`ifdef NDP84_ROUND_ROBIN_EN
  logic [2:0] last_q [4];
`endif

  // Per-lane queue status and head word.
  always_comb begin
    for (int unsigned n = 0; n < 8; n++) begin
      head[n]     = mem_q[n][rptr_q[n]];
      nonempty[n] = (cnt_q[n] != '0);
      full[n]     = (cnt_q[n] == cnt_t'(DEPTH));
      nf[n]       = (cnt_q[n] >= cnt_t'(DEPTH - 1));
    end
  end

  // Request matrix: lane n asks for the output named by its head ctl[1:0].
  always_comb begin
    for (int unsigned m = 0; m < 4; m++) begin
      req[m] = '0;
      for (int unsigned n = 0; n < 8; n++) begin
        req[m][n] = nonempty[n] && (head[n][DATA_WIDTH +: 2] == 2'(m));
      end
    end
  end

  // Per-output arbitration; a lane requests one output only, so at most one pop per lane.
  always_comb begin
    gnt_vld = '0;
    pop     = '0;
    idx     = '0;
    for (int unsigned m = 0; m < 4; m++) begin
      gnt_lane[m] = '0;
      for (int unsigned k = 0; k < 8; k++) begin
`ifdef NDP84_ROUND_ROBIN_EN
        idx = last_q[m] + 3'(k) + 3'd1;
`else
        idx = 3'(k);
`endif
        if (!gnt_vld[m] && req[m][idx]) begin
          gnt_vld[m]  = 1'b1;
          gnt_lane[m] = idx;
        end
      end
      if (gnt_vld[m]) pop[gnt_lane[m]] = 1'b1;
    end
  end

  // Write acceptance: a full queue still accepts when it is popped this cycle.
  always_comb begin
    for (int unsigned n = 0; n < 8; n++) begin
      push[n]  = wr[n] && (!full[n] || pop[n]);
      drop[n]  = wr[n] && full[n] && !pop[n];
      cnt_d[n] = cnt_q[n] + cnt_t'(push[n]) - cnt_t'(pop[n]);
    end
  end

  // Saturating drop counter; several lanes may drop in the same cycle.
  always_comb begin
    ndrop = '0;
    for (int unsigned n = 0; n < 8; n++) ndrop = ndrop + 4'(drop[n]);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(ndrop);
    drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  // Queue pointers, occupancy and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned n = 0; n < 8; n++) begin
        wptr_q[n] <= '0;
        rptr_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
      drop_cnt_q <= '0;
    end else begin
      for (int unsigned n = 0; n < 8; n++) begin
        if (push[n]) wptr_q[n] <= wptr_q[n] + ptr_t'(1);
        if (pop[n])  rptr_q[n] <= rptr_q[n] + ptr_t'(1);
        cnt_q[n] <= cnt_d[n];
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Queue storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 8; n++) begin
      if (push[n]) mem_q[n][wptr_q[n]] <= wword[n];
    end
  end

  // Output registers: strobe each granted cycle, hold payload otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr_q <= '0;
      for (int unsigned m = 0; m < 4; m++) out_word_q[m] <= '0;
    end else begin
      out_wr_q <= gnt_vld;
      for (int unsigned m = 0; m < 4; m++) begin
        if (gnt_vld[m]) out_word_q[m] <= head[gnt_lane[m]];
      end
    end
  end

`ifdef NDP84_ROUND_ROBIN_EN
  // Last-grant pointer per output, moved only when that output grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned m = 0; m < 4; m++) last_q[m] <= 3'd7;
    end else begin
      for (int unsigned m = 0; m < 4; m++) begin
        if (gnt_vld[m]) last_q[m] <= gnt_lane[m];
      end
    end
  end
`endif

  assign nearly_full = nf;
  assign drop_cnt    = drop_cnt_q;
  assign out_wr0     = out_wr_q[0];
  assign out_wr1     = out_wr_q[1];
  assign out_wr2     = out_wr_q[2];
  assign out_wr3     = out_wr_q[3];
  assign out_ctl0    = out_word_q[0][WW-1:DATA_WIDTH];
  assign out_ctl1    = out_word_q[1][WW-1:DATA_WIDTH];
  assign out_ctl2    = out_word_q[2][WW-1:DATA_WIDTH];
  assign out_ctl3    = out_word_q[3][WW-1:DATA_WIDTH];
  assign out_data0   = out_word_q[0][DATA_WIDTH-1:0];
  assign out_data1   = out_word_q[1][DATA_WIDTH-1:0];
  assign out_data2   = out_word_q[2][DATA_WIDTH-1:0];
  assign out_data3   = out_word_q[3][DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ndp8_4_merge.sv
// tb_ndp8_4_merge: directed bench for ndp8_4_merge with a per-output scoreboard.
// Expected order depends on NDP84_ROUND_ROBIN_EN, matching the DUT build.
`timescale 1ns/1ps
module tb_ndp8_4_merge;

  localparam int DW = 480;
  localparam int CW = 32;

  typedef logic [CW+DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr    [8];
  logic [CW-1:0] ctl   [8];
  logic [DW-1:0] data  [8];
  logic [7:0]    nearly_full;
  logic          owr   [4];
  logic [CW-1:0] octl  [4];
  logic [DW-1:0] odata [4];
  logic [15:0]   drop_cnt;
  logic [3:0]    owr_v;

  int    tests = 0;
  int    fails = 0;
  bit    mon_en = 1'b1;
  word_t sb [4][$];
  word_t mon_exp;

  assign owr_v = {owr[3], owr[2], owr[1], owr[0]};

  always #5 clk = ~clk;

  ndp8_4_merge #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH_BITS(2)) dut (
    .clk(clk), .rst(rst),
    .in_wr0(wr[0]), .in_ctl0(ctl[0]), .in_data0(data[0]),
    .in_wr1(wr[1]), .in_ctl1(ctl[1]), .in_data1(data[1]),
    .in_wr2(wr[2]), .in_ctl2(ctl[2]), .in_data2(data[2]),
    .in_wr3(wr[3]), .in_ctl3(ctl[3]), .in_data3(data[3]),
    .in_wr4(wr[4]), .in_ctl4(ctl[4]), .in_data4(data[4]),
    .in_wr5(wr[5]), .in_ctl5(ctl[5]), .in_data5(data[5]),
    .in_wr6(wr[6]), .in_ctl6(ctl[6]), .in_data6(data[6]),
    .in_wr7(wr[7]), .in_ctl7(ctl[7]), .in_data7(data[7]),
    .nearly_full(nearly_full),
    .out_wr0(owr[0]), .out_ctl0(octl[0]), .out_data0(odata[0]),
    .out_wr1(owr[1]), .out_ctl1(octl[1]), .out_data1(odata[1]),
    .out_wr2(owr[2]), .out_ctl2(octl[2]), .out_data2(odata[2]),
    .out_wr3(owr[3]), .out_ctl3(octl[3]), .out_data3(odata[3]),
    .drop_cnt(drop_cnt)
  );

  // Tagged word: upper ctl bits and both ends of the payload carry lane/index.
  function automatic word_t mk(input int lane, input int k, input int dst);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    c = {8'hC5, 8'(lane), 8'(k), 6'h15, 2'(dst)};
    d = '0;
    d[31:0]      = {16'hDA7A, 8'(lane), 8'(k)};
    d[DW-1 -: 16] = 16'hBEEF ^ 16'(lane);
    return {c, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int lane, input int k, input int dst);
    word_t w;
    w = mk(lane, k, dst);
    wr[lane] = 1'b1;
    {ctl[lane], data[lane]} = w;
  endtask

  task automatic idle();
    for (int n = 0; n < 8; n++) wr[n] = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    int pend;
    n = 0;
    pend = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
    while (pend != 0 && n < budget) begin
      tick();
      n++;
      pend = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
    end
    chk(tag, 64'(pend), 64'd0);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int m = 0; m < 4; m++) begin
        if (owr[m] === 1'b1) begin
          tests++;
          if (sb[m].size() == 0) begin
            assert (owr[m] === 1'b0) else begin
              fails++;
              $error("FAIL unexpected_wr%0d: observed ctl %0h data %0h expected no strobe",
                     m, octl[m], odata[m][31:0]);
            end
          end else begin
            mon_exp = sb[m].pop_front();
            assert ({octl[m], odata[m]} === mon_exp) else begin
              fails++;
              $error("FAIL out%0d_word: observed ctl %0h data %0h/%0h expected ctl %0h data %0h/%0h",
                     m, octl[m], odata[m][DW-1 -: 16], odata[m][31:0],
                     mon_exp[CW+DW-1 -: CW], mon_exp[DW-1 -: 16], mon_exp[31:0]);
            end
          end
        end
      end
    end
  end

  int         dexp [6];
  logic [5:0] nfexp;
  logic [3:0] seen;

  initial begin
    for (int n = 0; n < 8; n++) begin
      wr[n] = 1'b0;
      ctl[n] = '0;
      data[n] = '0;
    end

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_out_wr", 64'(owr_v), 64'd0);
    chk("rst_out_ctl2", 64'(octl[2]), 64'd0);
    chk("rst_out_data1", odata[1][63:0], 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_nearly_full", 64'(nearly_full), 64'd0);
    rst = 1'b1;
    tick();

    // Single word lane 3 -> output 2, two clocks strobe-to-strobe
    drive(3, 0, 2);
    sb[2].push_back(mk(3, 0, 2));
    tick();
    idle();
    chk("single_edge1_wr", 64'(owr_v), 64'd0);
    tick();
    chk("single_edge2_wr", 64'(owr_v), 64'b0100);
    drain("single_drain", 10);

    // Parallel: lanes 0..3 to outputs 3..0 in one cycle
    for (int n = 0; n < 4; n++) begin
      drive(n, 0, 3 - n);
      sb[3 - n].push_back(mk(n, 0, 3 - n));
    end
    tick();
    idle();
    chk("parallel_edge1_wr", 64'(owr_v), 64'd0);
    tick();
    chk("parallel_edge2_wr", 64'(owr_v), 64'b1111);
    drain("parallel_drain", 10);

    // Contention: lanes 0,1,2 hold two words each for output 1
    do_reset();
`ifdef NDP84_ROUND_ROBIN_EN
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 3; n++) sb[1].push_back(mk(n, k, 1));
`else
    for (int n = 0; n < 3; n++)
      for (int k = 0; k < 2; k++) sb[1].push_back(mk(n, k, 1));
`endif
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 3; n++) drive(n, k, 1);
      tick();
    end
    idle();
    drain("contention_drain", 30);

    // Overflow: lanes 0 and 5 write six back-to-back words to output 0
    do_reset();
`ifdef NDP84_ROUND_ROBIN_EN
    nfexp = 6'b111000;
    dexp  = '{0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      sb[0].push_back(mk(0, k, 0));
      sb[0].push_back(mk(5, k, 0));
    end
`else
    nfexp = 6'b111100;
    dexp  = '{0, 0, 0, 0, 1, 2};
    for (int k = 0; k < 6; k++) sb[0].push_back(mk(0, k, 0));
    for (int k = 0; k < 4; k++) sb[0].push_back(mk(5, k, 0));
`endif
    for (int k = 0; k < 6; k++) begin
      drive(0, k, 0);
      drive(5, k, 0);
      tick();
      chk($sformatf("ovf_nearly_full5_e%0d", k + 1), 64'(nearly_full[5]), 64'(nfexp[k]));
      chk($sformatf("ovf_drop_cnt_e%0d", k + 1), 64'(drop_cnt), 64'(dexp[k]));
    end
    idle();
    drain("ovf_drain", 40);
    chk("ovf_drop_final", 64'(drop_cnt), 64'(dexp[5]));

    // Reset mid-traffic: three words queued, none may emerge
    drive(4, 0, 3);
    drive(5, 0, 3);
    drive(6, 0, 3);
    tick();
    idle();
    rst = 1'b0;
    #1;
    chk("midrst_out_wr", 64'(owr_v), 64'd0);
    chk("midrst_out_ctl0", 64'(octl[0]), 64'd0);
    chk("midrst_out_data0", odata[0][63:0], 64'd0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("midrst_nearly_full", 64'(nearly_full), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("postrst_first_edge_wr", 64'(owr_v), 64'd0);
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | owr_v;
    end
    chk("postrst_no_stale", 64'(seen), 64'd0);

    // Drop counter saturation: all lanes flood output 0
    do_reset();
    mon_en = 1'b0;
    for (int n = 0; n < 8; n++) drive(n, 0, 0);
`ifdef NDP84_ROUND_ROBIN_EN
    repeat (9400) tick();
    chk("sat_nearly_full", 64'(nearly_full), 64'hFF);
    chk("sat_drop_cnt", 64'(drop_cnt), 64'hFFFF);
`else
    repeat (9366) tick();
    chk("sat_nearly_full", 64'(nearly_full), 64'hFE);
    chk("sat_drop_cnt_below", 64'(drop_cnt), 64'hFFFE);
    tick();
    chk("sat_drop_cnt", 64'(drop_cnt), 64'hFFFF);
`endif
    repeat (10) tick();
    chk("sat_drop_cnt_hold", 64'(drop_cnt), 64'hFFFF);
    do_reset();
    chk("sat_drop_cnt_cleared", 64'(drop_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
